// File: rtl/imm_ext_pkg.sv
// Shared constants for the ID-stage immediate-extension arbiter.
// No logic; mode encodings and requester indices only.
// Not applicable (package).
package imm_ext_pkg;

    // Extension mode encodings
    localparam logic [1:0] MODE_SEXT = 2'b00;
    localparam logic [1:0] MODE_ZEXT = 2'b01;
    localparam logic [1:0] MODE_LUI  = 2'b10;
    localparam logic [1:0] MODE_BOFF = 2'b11;

    // Requester indices as reported on rsp_src
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_BR  = 1'b1;

endpackage

// File: rtl/imm_ext_core.sv
// Extends a 16-bit immediate to 32 bits according to a 2-bit mode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module imm_ext_core
    import imm_ext_pkg::*;
(
    input  logic [15:0] imm,
    input  logic [1:0]  mode,
    output logic [31:0] out
);

    // Select the extension; branch offsets are word-aligned so shifted left by two
    always_comb begin
        out = 32'h0000_0000;
        case (mode)
            MODE_SEXT: out = {{16{imm[15]}}, imm};
            MODE_ZEXT: out = {16'h0000, imm};
            MODE_LUI:  out = {imm, 16'h0000};
            MODE_BOFF: out = {{14{imm[15]}}, imm, 2'b00};
            default:   out = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between ALU and branch requesters.
// Latency: request accepted in cycle t is presented on rsp_* in cycle t+1.
// Backpressure: readys drop and all state freezes while rsp_valid=1 and rsp_ready=0.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
)
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_imm,
    input  logic [1:0]       req0_mode,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_imm,
    input  logic [1:0]       req1_mode,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             can_accept;
    logic             gnt0;
    logic             gnt1;
    logic             ptr;
    logic [15:0]      sel_imm;
    logic [1:0]       sel_mode;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      ext_dat;

    // Grant decision: a lone requester wins, contention goes to the pointer; no grant in reset
    always_comb begin
        can_accept = !rsp_valid || rsp_ready;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!Reset && can_accept) begin
            if (req0_valid && req1_valid) begin
                gnt0 = (ptr == REQ_ALU);
                gnt1 = (ptr == REQ_BR);
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Steer the granted request into the single shared extender
    always_comb begin
        sel_imm  = req0_imm;
        sel_mode = req0_mode;
        sel_tag  = req0_tag;
        if (gnt1) begin
            sel_imm  = req1_imm;
            sel_mode = req1_mode;
            sel_tag  = req1_tag;
        end
    end

    imm_ext_core u_core (
        .imm  (sel_imm),
        .mode (sel_mode),
        .out  (ext_dat)
    );

    // Response register, round-robin pointer and saturating grant counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'h0000_0000;
            rsp_src    <= REQ_ALU;
            rsp_tag    <= '0;
            ptr        <= REQ_ALU;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (can_accept) begin
            rsp_valid <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                rsp_data <= ext_dat;
                rsp_src  <= gnt1 ? REQ_BR : REQ_ALU;
                rsp_tag  <= sel_tag;
                // Pointer always moves to the other requester after any grant
                ptr      <= gnt1 ? REQ_ALU : REQ_BR;
            end
            if (gnt0 && grant_cnt0 != CNT_MAX) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (gnt1 && grant_cnt1 != CNT_MAX) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: directed scenarios followed by random traffic against a reference model.
// Latency: model expects responses one cycle after acceptance.
// Backpressure: rsp_ready is driven directly and randomly in the random phase.
module tb_imm_ext_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_imm = '0, req1_imm = '0;
    logic [1:0]  req0_mode = '0, req1_mode = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_src;
    logic [3:0]  rsp_tag;
    logic [7:0]  grant_cnt0, grant_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_vld;
    logic [31:0] m_dat;
    bit          m_src;
    logic [3:0]  m_tag;
    bit          m_ptr;
    int          m_cnt0, m_cnt1;

    imm_ext_arbiter #(.TAG_W(4), .CNT_W(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_src    (rsp_src),
        .rsp_tag    (rsp_tag),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Arithmetic view of the extension modes
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        int s;
        s = (int'(imm) >= 32768) ? int'(imm) - 65536 : int'(imm);
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return 32'(int'(imm));
            2'd2:    return 32'(int'(imm) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic model_reset();
        m_vld = 0; m_dat = '0; m_src = 0; m_tag = '0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    // One clock: drive inputs, check everything at the falling edge, advance the model
    task automatic cycle(input bit v0, input logic [15:0] i0, input logic [1:0] md0, input logic [3:0] t0,
                         input bit v1, input logic [15:0] i1, input logic [1:0] md1, input logic [3:0] t1,
                         input bit rr);
        bit can, g0, g1;
        req0_valid = v0; req0_imm = i0; req0_mode = md0; req0_tag = t0;
        req1_valid = v1; req1_imm = i1; req1_mode = md1; req1_tag = t1;
        rsp_ready  = rr;
        @(negedge Clk);
        can = !m_vld || rr;
        g0 = 0; g1 = 0;
        if (can) begin
            if (v0 && v1) begin
                if (m_ptr) g1 = 1; else g0 = 1;
            end else begin
                g0 = v0; g1 = v1;
            end
        end
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
        if (m_vld) begin
            chk("rsp_data", rsp_data, m_dat);
            chk("rsp_src", 32'(rsp_src), 32'(m_src));
            chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
        end
        chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
        chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
        if (can) begin
            m_vld = g0 || g1;
            if (g0 || g1) begin
                m_src = g1;
                m_dat = g1 ? ref_ext(i1, md1) : ref_ext(i0, md0);
                m_tag = g1 ? t1 : t0;
                m_ptr = !g1;
                if (g1) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
                else    m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input bit v0, input bit v1, input bit rr);
        Reset = 1'b1;
        req0_valid = v0; req1_valid = v1; rsp_ready = rr;
        @(negedge Clk);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_src", 32'(rsp_src), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
        chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
    endtask

    initial begin
        logic [31:0] held_dat;
        logic        held_src;
        logic [3:0]  held_tag;

        model_reset();
        do_reset(1, 1, 1);

        // Lone ALU request, sign-extend
        cycle(1, 16'h8001, 2'b00, 4'd3, 0, 16'h0, 2'b00, 4'd0, 1);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_data", rsp_data, 32'hFFFF_8001);
        chk("t1_src", 32'(rsp_src), 32'd0);
        chk("t1_tag", 32'(rsp_tag), 32'd3);
        chk("t1_cnt0", 32'(grant_cnt0), 32'd1);

        // Lone branch requests across the other modes
        cycle(0, 16'h0, 2'b00, 4'd0, 1, 16'hFFFE, 2'b11, 4'd5, 1);
        chk("boff_data", rsp_data, 32'hFFFF_FFF8);
        chk("boff_src", 32'(rsp_src), 32'd1);
        cycle(0, 16'h0, 2'b00, 4'd0, 1, 16'h1234, 2'b10, 4'd6, 1);
        chk("lui_data", rsp_data, 32'h1234_0000);
        cycle(0, 16'h0, 2'b00, 4'd0, 1, 16'h8000, 2'b01, 4'd7, 1);
        chk("zext_data", rsp_data, 32'h0000_8000);

        // Continuous contention alternates starting from requester 0
        do_reset(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 16'(i), 2'b01, 4'd1, 1, 16'(i + 100), 2'b01, 4'd2, 1);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_src", 32'(rsp_src), 32'(i % 2));
        end
        chk("rr_cnt0", 32'(grant_cnt0), 32'd3);
        chk("rr_cnt1", 32'(grant_cnt1), 32'd3);

        // Stalled response: readys low, outputs frozen
        held_dat = rsp_data; held_src = rsp_src; held_tag = rsp_tag;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 16'hAAAA, 2'b00, 4'd9, 1, 16'h5555, 2'b00, 4'd10, 0);
            chk("bp_data", rsp_data, held_dat);
            chk("bp_src", 32'(rsp_src), 32'(held_src));
            chk("bp_tag", 32'(rsp_tag), 32'(held_tag));
            chk("bp_cnt0", 32'(grant_cnt0), 32'd3);
        end
        // Release: pointer names requester 0, no bubble
        cycle(1, 16'hAAAA, 2'b00, 4'd9, 1, 16'h5555, 2'b00, 4'd10, 1);
        chk("bp_rel_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rel_src", 32'(rsp_src), 32'd0);
        chk("bp_rel_data", rsp_data, 32'hFFFF_AAAA);

        // Drain with no new request drops rsp_valid
        cycle(0, 16'h0, 2'b00, 4'd0, 0, 16'h0, 2'b00, 4'd0, 1);
        chk("drain_valid", 32'(rsp_valid), 32'd0);

        // Reset while a response is pending and both request
        cycle(0, 16'h0, 2'b00, 4'd0, 1, 16'h0042, 2'b00, 4'd4, 0);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        do_reset(1, 1, 0);
        cycle(1, 16'h0001, 2'b00, 4'd1, 1, 16'h0002, 2'b00, 4'd2, 1);
        chk("post_rst_src", 32'(rsp_src), 32'd0);
        chk("post_rst_cnt0", 32'(grant_cnt0), 32'd1);

        // Counter saturation
        do_reset(0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            cycle(1, 16'($urandom), 2'($urandom), 4'($urandom), 0, 16'h0, 2'b00, 4'd0, 1);
        end
        chk("sat_cnt0", 32'(grant_cnt0), 32'd255);
        chk("sat_cnt1", 32'(grant_cnt1), 32'd0);

        // Random traffic with random backpressure
        do_reset(0, 0, 1);
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
